// File: rtl/hall_pattern_gen_pkg.sv
// Shared actuator definitions: Hall ring ordering, reset code and generator states.
// The Hall position decoder uses the same ring, so both sides agree on direction.
package hall_pattern_gen_pkg;

    localparam int         HALL_RING_LEN   = 6;
    localparam logic [2:0] HALL_RESET_CODE = 3'b001;

    localparam logic [2:0] HALL_CODE_0 = 3'b001;
    localparam logic [2:0] HALL_CODE_1 = 3'b011;
    localparam logic [2:0] HALL_CODE_2 = 3'b010;
    localparam logic [2:0] HALL_CODE_3 = 3'b110;
    localparam logic [2:0] HALL_CODE_4 = 3'b100;
    localparam logic [2:0] HALL_CODE_5 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } gen_state_e;

    // Ring index to Hall code; an out-of-range index maps to the reset code.
    function automatic logic [2:0] hall_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = HALL_CODE_0;
            3'd1:    code = HALL_CODE_1;
            3'd2:    code = HALL_CODE_2;
            3'd3:    code = HALL_CODE_3;
            3'd4:    code = HALL_CODE_4;
            3'd5:    code = HALL_CODE_5;
            default: code = HALL_RESET_CODE;
        endcase
        return code;
    endfunction

    // Next ring index, modulo the ring length, in either direction.
    function automatic logic [2:0] ring_next(input logic [2:0] idx, input logic bwd);
        logic [2:0] nxt;
        if (bwd)
            nxt = (idx == 3'd0) ? 3'(HALL_RING_LEN - 1) : idx - 3'd1;
        else
            nxt = (idx == 3'(HALL_RING_LEN - 1)) ? 3'd0 : idx + 3'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/hall_ring_step.sv
// Mod-6 Hall ring walker: advances one position per step and registers the Hall code.
module hall_ring_step
    import hall_pattern_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_step,
    input  logic       i_bwd,
    output logic [2:0] o_hall
);

    logic [2:0] r_idx;
    logic [2:0] r_hall;
    logic [2:0] w_idx_next;

    // Neighbouring ring index in the requested direction.
    always_comb begin
        w_idx_next = ring_next(r_idx, i_bwd);
    end

    // Index and code move together so the output is a plain register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= 3'd0;
            r_hall <= HALL_RESET_CODE;
        end else if (i_step) begin
            r_idx  <= w_idx_next;
            r_hall <= hall_code(w_idx_next);
        end
    end

    assign o_hall = r_hall;

endmodule

// File: rtl/hall_pattern_gen.sv
// Hall pattern generator: walks a virtual rotor to a commanded target, one Hall edge per period.
//
//   state | meaning
//   IDLE  | ready for a command; outputs hold
//   RUN   | period counter running, one step each time it expires
//   FIN   | target reached; done pulses for this cycle
module hall_pattern_gen
    import hall_pattern_gen_pkg::*;
#(
    parameter int POS_W = 32,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             stop,
    output logic [2:0]       hall,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    gen_state_e       r_state;
    logic [POS_W-1:0] r_position;
    logic [POS_W-1:0] r_target;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [PER_W-1:0] w_period_eff;
    logic [POS_W-1:0] w_accept_diff;
    logic [POS_W-1:0] w_diff;
    logic             w_bwd;
    logic             w_step;
    logic [POS_W-1:0] w_pos_next;

    // Direction from the signed modular distance; the exact half range counts as backward.
    always_comb begin
        w_period_eff  = (cmd_period == '0) ? PER_W'(1) : cmd_period;
        w_accept_diff = cmd_target - r_position;
        w_diff        = r_target - r_position;
        w_bwd         = w_diff[POS_W-1];
        w_step        = (r_state == ST_RUN) && !stop && (r_cnt == '0);
        w_pos_next    = w_bwd ? (r_position - POS_W'(1)) : (r_position + POS_W'(1));
    end

    // Sequencing FSM with period counter, position register and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_position <= '0;
            r_target   <= '0;
            r_period   <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_target <= cmd_target;
                        r_period <= w_period_eff;
                        r_cnt    <= w_period_eff - PER_W'(1);
                        r_ready  <= 1'b0;
                        if (w_accept_diff == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Abort leaves hall and position where they are.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_position <= w_pos_next;
                        r_cnt      <= r_period - PER_W'(1);
                        if (w_pos_next == r_target) begin
                            r_state <= ST_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - PER_W'(1);
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    hall_ring_step u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  (w_step),
        .i_bwd   (w_bwd),
        .o_hall  (hall)
    );

    assign cmd_ready = r_ready;
    assign position  = r_position;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_hall_pattern_gen.sv
// Self-checking bench for hall_pattern_gen: directed and randomized moves against a
// cycle-level reference of the stepping rules plus an independent Hall decoder model.
module tb_hall_pattern_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] cmd_target = 32'd0;
    logic [15:0] cmd_period = 16'd0;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [2:0]  hall;
    logic [31:0] position;

    int errors = 0;
    int checks = 0;

    logic [2:0]  ring [6];
    logic [31:0] m_pos;
    int          m_idx;
    logic [31:0] dec_pos;
    int          dec_idx;
    logic [2:0]  prev_hall;

    always #5 clk = ~clk;

    hall_pattern_gen #(.POS_W(32), .PER_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_period (cmd_period),
        .stop       (stop),
        .hall       (hall),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [2:0] code);
        for (int i = 0; i < 6; i++)
            if (ring[i] == code) return i;
        return -1;
    endfunction

    // Decoder model: counts ring transitions seen on hall, must track position.
    task automatic decoder_update();
        int ni;
        int d;
        ni = idx_of(hall);
        chk("hall_legal", 32'(ni >= 0), 32'd1);
        chk("hall_one_bit", 32'($countones(hall ^ prev_hall) <= 1), 32'd1);
        if (ni >= 0) begin
            d = (ni - dec_idx + 6) % 6;
            if (d == 1) dec_pos = dec_pos + 32'd1;
            else if (d == 5) dec_pos = dec_pos - 32'd1;
            dec_idx = ni;
        end
        prev_hall = hall;
        chk("decoder_pos", position, dec_pos);
    endtask

    task automatic check_cycle(input string tag, input bit busy_e, input bit done_e, input bit ready_e);
        chk({tag, "_hall"},  32'(hall), 32'(ring[m_idx]));
        chk({tag, "_pos"},   position, m_pos);
        chk({tag, "_busy"},  32'(busy), 32'(busy_e));
        chk({tag, "_done"},  32'(done), 32'(done_e));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'(ready_e));
        decoder_update();
    endtask

    // Assert reset away from a clock edge; outputs must clear without waiting for a clock.
    task automatic do_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        stop = 1'b0;
        #1;
        chk("rst_hall",  32'(hall), 32'h1);
        chk("rst_pos",   position, 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        m_pos = 32'd0;
        m_idx = 0;
        dec_pos = 32'd0;
        dec_idx = 0;
        prev_hall = 3'b001;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Issue one command and follow it cycle by cycle. stop_c > 0 raises stop so it is
    // sampled at edge T0+stop_c; poke fires an extra command while busy that must be ignored.
    task automatic move(input logic [31:0] tgt, input int per, input int stop_c,
                        input bit stop_idle, input bit poke);
        logic [31:0] d;
        logic [31:0] nd;
        bit          bwd;
        int          p;
        int          last;
        int          wc;
        bit          stopped;
        bit          be;
        bit          de;
        bit          re;
        int          c_end;
        p = (per == 0) ? 1 : per;
        d = tgt - m_pos;
        bwd = d[31];
        nd = bwd ? (32'd0 - d) : d;
        last = int'(nd) * p;
        stopped = (stop_c > 0) && (stop_c <= last);
        wc = 0;
        while (!cmd_ready && wc < 50) begin
            @(posedge clk);
            #1;
            wc++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_target = tgt;
        cmd_period = 16'(per);
        stop = stop_idle;
        @(posedge clk);
        #1;
        cmd_target = $urandom;
        c_end = stopped ? stop_c + 1 : last + 2;
        for (int c = 0; c <= c_end; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cmd_valid = 1'b0;
            stop = 1'b0;
            if (c > 0 && (c % p) == 0 && c <= last && !(stopped && c >= stop_c)) begin
                if (bwd) begin
                    m_pos = m_pos - 32'd1;
                    m_idx = (m_idx + 5) % 6;
                end else begin
                    m_pos = m_pos + 32'd1;
                    m_idx = (m_idx + 1) % 6;
                end
            end
            if (stopped && c >= stop_c) begin
                be = 1'b0; de = 1'b0; re = 1'b1;
            end else begin
                be = (c < last); de = (c == last); re = (c > last);
            end
            check_cycle("mv", be, de, re);
            if (stopped && c == stop_c - 1) stop = 1'b1;
            if (poke && c == 1 && last >= 2 && (!stopped || stop_c > 2)) begin
                cmd_valid = 1'b1;
                cmd_target = m_pos + 32'd7;
                cmd_period = 16'd1;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int off;
        int per;
        int sc;
        ring[0] = 3'b001; ring[1] = 3'b011; ring[2] = 3'b010;
        ring[3] = 3'b110; ring[4] = 3'b100; ring[5] = 3'b101;
        #2;
        do_reset();

        // Three forward steps at period 4.
        move(32'd3, 4, 0, 1'b0, 1'b0);
        chk("t1_pos", position, 32'd3);
        chk("t1_hall", 32'(hall), 32'b110);

        // Backward across zero.
        do_reset();
        move(32'hFFFF_FFFE, 1, 0, 1'b0, 1'b0);
        chk("t2_pos", position, 32'hFFFF_FFFE);
        chk("t2_hall", 32'(hall), 32'b100);

        // Zero distance, with stop held in IDLE at accept (no effect).
        move(32'hFFFF_FFFE, 5, 0, 1'b1, 1'b0);

        // Period 0 behaves as 1; a full ring returns to 001.
        do_reset();
        move(32'd6, 0, 0, 1'b0, 1'b1);
        chk("t4_pos", position, 32'd6);
        chk("t4_hall", 32'(hall), 32'b001);

        // Abort mid-period and on a step-due edge.
        do_reset();
        move(32'd100, 10, 35, 1'b0, 1'b0);
        chk("t5_pos", position, 32'd3);
        move(32'd100, 10, 40, 1'b0, 1'b0);
        chk("t6_pos", position, 32'd6);

        // Random short moves in both directions.
        for (int k = 0; k < 14; k++) begin
            off = int'($urandom_range(60)) - 30;
            per = int'($urandom_range(5));
            sc = ($urandom_range(3) == 0) ? int'($urandom_range(60, 1)) : 0;
            move(m_pos + 32'(off), per, sc, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Async reset in the middle of a move.
        cmd_valid = 1'b1;
        cmd_target = m_pos + 32'd50;
        cmd_period = 16'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
        end
        do_reset();
        move(32'd2, 2, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hall_pattern_gen.md
# hall_pattern_gen

Generates a 3-bit Hall-sensor code stream that moves a virtual rotor from its current position to a commanded target position, one Hall edge per programmable step period. Drives the Hall inputs of the servo controller's Hall position decoder in the actuator path, for motor-less bring-up, HIL loopback and closed-loop position regression. Position counting, Hall ordering and wrap rules mirror the decoder, so a decoder attached to `hall` tracks `position` exactly.

## Interface
- `POS_W`, 32, width of position and target.
- `PER_W`, 16, width of step period.
- `clk` input 1 — system clock.
- `reset_n` input 1 — asynchronous active-low reset.
- `cmd_valid` input 1 — target command valid.
- `cmd_ready` output 1 — generator idle, can accept a command.
- `cmd_target` input POS_W — target position, modular.
- `cmd_period` input PER_W — clocks per Hall edge; 0 is treated as 1.
- `stop` input 1 — abort motion.
- `hall` output 3 — Hall code {a,b,c}, registered.
- `position` output POS_W — current virtual position, registered.
- `busy` output 1 — motion in progress.
- `done` output 1 — one-cycle pulse when target reached.

## Operation
- Hall ring, index 0..5: 001, 011, 010, 110, 100, 101.
- Forward step: index +1 mod 6, `position` +1. Backward step: index −1 mod 6, `position` −1.
- `position` wraps modulo 2^POS_W (0xFFFFFFFF+1 = 0).
- Direction: diff = `cmd_target` − `position` mod 2^POS_W, read as signed.
  - diff > 0 steps forward.
  - MSB set steps backward.
  - Exact half-range (diff = 0x80000000) steps backward.
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch target and period (0→1), load the period counter with period−1, then:
    - diff = 0: go to FIN.
    - otherwise: go to RUN.
  - RUN: `busy`=1. The counter decrements each clock. At 0:
    - take one step;
    - reload the counter;
    - if the new position equals the target, go to FIN.
  - FIN: assert `done` for one cycle, return to IDLE.
- `stop` high in RUN:
  - return to IDLE on the next edge with no further step;
  - `done` not asserted;
  - `hall` and `position` hold.
- `stop` in IDLE or FIN has no effect.
- Simultaneous `stop` and step-due in RUN: `stop` wins, no step.
- `cmd_valid` while not ready is ignored; it is not queued.
- Reset, any time, including mid-motion: state IDLE, `hall`=001, `position`=0, `busy`=0, `done`=0, `cmd_ready`=1, counter 0.
- Exactly one `hall` bit changes per step. `hall` never takes 000 or 111.

## Timing
- Acceptance at edge T0. With period P (P≥1):
  - first step visible at T0+P;
  - subsequent steps every P clocks.
- Moving N steps: last step at T0+N·P, `done` high in cycle T0+N·P+1, `cmd_ready` high from T0+N·P+2.
- Zero-distance command: `done` high in cycle T0+1, ready at T0+2.
- `busy` high from T0+1 through the cycle of the last step.
- `hall` and `position` update on the same edge; there is no combinational path from inputs to outputs.
- `cmd_ready` depends on state only.

## Structure
- Shared actuator package holds:
  - the Hall ring constants (the six codes, index→code);
  - reset code 001;
  - FSM state enum (IDLE, RUN, FIN).
- These are shared with the Hall position decoder, so both use one ordering.
- One natural sub-module: `hall_ring_step`. It holds the mod-6 index register, takes step and direction inputs, and outputs the Hall code.
- Top holds the FSM, period counter, position register and direction compare.

## Test plan
- Reset, then target=3, period=4 → `hall` 011 @T0+4, 010 @T0+8, 110 @T0+12; `position`=3; `done` @T0+13.
- From 0, target=0xFFFFFFFE, period=1 → backward steps, `hall` 101 then 100; `position`=0xFFFFFFFE; 2 steps.
- target=position, any period → no `hall` change; `done` one cycle after accept.
- period=0, target=6 → one step per clock; `hall` returns to 001 after 6 steps; `position`=6.
- target=100, period=10, `stop` at T0+35 → 3 steps taken, `position`=3, IDLE, no `done`. Same test with `stop` on a step-due cycle → no step that cycle.
- Loopback to the Hall position decoder over random targets and periods → decoder position equals `position` (one-cycle lag). Async reset mid-motion → all outputs at reset values immediately.
